// File: rtl/pwd_keypad_entry_if.sv
// Keypad-side signal bundle for pwd_keypad_entry: raw buttons and arm in,
// password digits and status out.
interface pwd_keypad_entry_if;
  logic       arm;
  logic [3:0] btn_digit;
  logic       btn_clear;
  logic       btn_enter;
  logic [1:0] password_1;
  logic [1:0] password_2;
  logic       pwd_valid;
  logic       entry_active;
  logic [1:0] digit_count;
  logic       timeout_err;

  modport master (
    output arm, btn_digit, btn_clear, btn_enter,
    input  password_1, password_2, pwd_valid, entry_active, digit_count, timeout_err
  );

  modport slave (
    input  arm, btn_digit, btn_clear, btn_enter,
    output password_1, password_2, pwd_valid, entry_active, digit_count, timeout_err
  );
endinterface

// File: rtl/pwd_keypad_entry.sv
// Entrance keypad front end: synchronises and debounces six buttons, sequences
// two password digits plus enter, and presents them to the gate controller.
module pwd_keypad_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 100000
) (
  input  logic                clk,
  input  logic                reset_n,
  pwd_keypad_entry_if.slave   kp
);

  localparam int unsigned NBTN = 6;
  localparam int unsigned DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  TMO_MAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_D1,
    S_WAIT_D2,
    S_WAIT_ENTER,
    S_SUBMIT,
    S_HOLD
  } state_t;

  // ---------------- input conditioning ----------------
  logic [NBTN-1:0] w_raw;
  logic [NBTN-1:0] r_sync1;
  logic [NBTN-1:0] r_sync2;
  logic [NBTN-1:0] r_level;
  logic [NBTN-1:0] r_press;
  logic [DBW-1:0]  r_db_cnt [NBTN];

  assign w_raw = {kp.btn_enter, kp.btn_clear, kp.btn_digit};

  // Press pulse is raised on the same edge the debounced level rises,
  // giving DEBOUNCE_CYCLES+2 cycles from raw rise to a visible event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_press <= '0;
      for (int unsigned i = 0; i < NBTN; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_press <= '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_cnt[i] <= '0;
          r_level[i]  <= r_sync2[i];
          r_press[i]  <= r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // ---------------- event decode ----------------
  logic [3:0] w_dig;
  logic       w_clr;
  logic       w_ent;
  logic       w_dig_one;
  logic [1:0] w_dig_val;

  assign w_dig     = r_press[3:0];
  assign w_clr     = r_press[4];
  assign w_ent     = r_press[5];
  assign w_dig_one = (w_dig != 4'd0) && ((w_dig & (w_dig - 4'd1)) == 4'd0);

  always_comb begin
    w_dig_val = 2'd0;
    case (w_dig)
      4'b0010: w_dig_val = 2'd1;
      4'b0100: w_dig_val = 2'd2;
      4'b1000: w_dig_val = 2'd3;
      default: w_dig_val = 2'd0;
    endcase
  end

  // ---------------- sequencing FSM ----------------
  state_t         r_state;
  state_t         w_state_nxt;
  logic [1:0]     r_d1;
  logic [1:0]     r_d2;
  logic [1:0]     w_d1_nxt;
  logic [1:0]     w_d2_nxt;
  logic [TW-1:0]  r_tcnt;
  logic [TW-1:0]  w_tcnt_nxt;
  logic           w_waiting;
  logic           w_tmo_hit;
  logic           w_accept;
  logic           w_tmo_fire;

  logic [1:0]     r_pw1;
  logic [1:0]     r_pw2;
  logic           r_valid;
  logic           r_active;
  logic [1:0]     r_cnt;
  logic           r_tmo;
  logic [1:0]     w_pw1_nxt;
  logic [1:0]     w_pw2_nxt;
  logic           w_valid_nxt;
  logic           w_active_nxt;
  logic [1:0]     w_cnt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_d1     <= '0;
      r_d2     <= '0;
      r_tcnt   <= '0;
      r_pw1    <= '0;
      r_pw2    <= '0;
      r_valid  <= 1'b0;
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_tmo    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_d1     <= w_d1_nxt;
      r_d2     <= w_d2_nxt;
      r_tcnt   <= w_tcnt_nxt;
      r_pw1    <= w_pw1_nxt;
      r_pw2    <= w_pw2_nxt;
      r_valid  <= w_valid_nxt;
      r_active <= w_active_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tmo    <= w_tmo_fire;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_d1_nxt    = r_d1;
    w_d2_nxt    = r_d2;
    w_accept    = 1'b0;
    w_tmo_fire  = 1'b0;
    w_waiting   = (r_state == S_WAIT_D1) || (r_state == S_WAIT_D2) ||
                  (r_state == S_WAIT_ENTER);
    w_tmo_hit   = w_waiting && (r_tcnt >= TMO_LAST);

    // Losing arm overrides every key event and the timeout.
    if ((r_state != S_IDLE) && !kp.arm) begin
      w_state_nxt = S_IDLE;
      w_d1_nxt    = '0;
      w_d2_nxt    = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (kp.arm) w_state_nxt = S_WAIT_D1;
        end
        S_WAIT_D1: begin
          if (w_clr) begin
            w_accept = 1'b1;
            w_d1_nxt = '0;
            w_d2_nxt = '0;
          end else if (w_dig_one) begin
            w_accept    = 1'b1;
            w_d1_nxt    = w_dig_val;
            w_state_nxt = S_WAIT_D2;
          end else if (w_tmo_hit) begin
            w_tmo_fire = 1'b1;
            w_d1_nxt   = '0;
            w_d2_nxt   = '0;
          end
        end
        S_WAIT_D2: begin
          if (w_clr) begin
            w_accept    = 1'b1;
            w_d1_nxt    = '0;
            w_d2_nxt    = '0;
            w_state_nxt = S_WAIT_D1;
          end else if (w_dig_one) begin
            w_accept    = 1'b1;
            w_d2_nxt    = w_dig_val;
            w_state_nxt = S_WAIT_ENTER;
          end else if (w_tmo_hit) begin
            w_tmo_fire  = 1'b1;
            w_d1_nxt    = '0;
            w_d2_nxt    = '0;
            w_state_nxt = S_WAIT_D1;
          end
        end
        S_WAIT_ENTER: begin
          if (w_clr) begin
            w_accept    = 1'b1;
            w_d1_nxt    = '0;
            w_d2_nxt    = '0;
            w_state_nxt = S_WAIT_D1;
          end else if (w_ent) begin
            w_accept    = 1'b1;
            w_state_nxt = S_SUBMIT;
          end else if (w_tmo_hit) begin
            w_tmo_fire  = 1'b1;
            w_d1_nxt    = '0;
            w_d2_nxt    = '0;
            w_state_nxt = S_WAIT_D1;
          end
        end
        S_SUBMIT: w_state_nxt = S_HOLD;
        S_HOLD: begin
          if (w_clr) begin
            w_d1_nxt    = '0;
            w_d2_nxt    = '0;
            w_state_nxt = S_WAIT_D1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // Idle timer restarts on any state change, accepted key or timeout.
    if (!w_waiting || (w_state_nxt != r_state) || w_accept || w_tmo_fire)
      w_tcnt_nxt = '0;
    else if (r_tcnt != TMO_MAX)
      w_tcnt_nxt = r_tcnt + TW'(1);
    else
      w_tcnt_nxt = r_tcnt;

    // Outputs are registered from the next state so they line up with it.
    w_valid_nxt  = (w_state_nxt == S_SUBMIT);
    w_active_nxt = (w_state_nxt != S_IDLE);
    case (w_state_nxt)
      S_SUBMIT: begin
        w_pw1_nxt = r_d1;
        w_pw2_nxt = r_d2;
      end
      S_HOLD: begin
        w_pw1_nxt = r_pw1;
        w_pw2_nxt = r_pw2;
      end
      default: begin
        w_pw1_nxt = '0;
        w_pw2_nxt = '0;
      end
    endcase
    case (w_state_nxt)
      S_WAIT_D2:                       w_cnt_nxt = 2'd1;
      S_WAIT_ENTER, S_SUBMIT, S_HOLD:  w_cnt_nxt = 2'd2;
      default:                         w_cnt_nxt = 2'd0;
    endcase
  end

  assign kp.password_1   = r_pw1;
  assign kp.password_2   = r_pw2;
  assign kp.pwd_valid    = r_valid;
  assign kp.entry_active = r_active;
  assign kp.digit_count  = r_cnt;
  assign kp.timeout_err  = r_tmo;

endmodule

// File: tb/tb_pwd_keypad_entry.sv
// Self-checking bench for pwd_keypad_entry with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50.
module tb_pwd_keypad_entry;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   nvalid;
  int   npushed;
  bit   tmo_allow;
  logic [3:0] sb_q [$];
  logic [3:0] sb_exp;

  pwd_keypad_entry_if kp_if ();

  pwd_keypad_entry #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (50)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .kp     (kp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        arm;
    logic [3:0]  dig;
    logic        clr;
    logic        ent;
    int unsigned hold;
    logic [1:0]  exp_cnt;
    logic        exp_act;
    logic [1:0]  exp_p1;
    logic [1:0]  exp_p2;
    logic        push;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic a, input logic [3:0] d, input logic c, input logic e,
                              input int unsigned h, input logic [1:0] cnt, input logic act,
                              input logic [1:0] p1, input logic [1:0] p2, input logic push);
    vec_t v;
    v.arm = a; v.dig = d; v.clr = c; v.ent = e; v.hold = h;
    v.exp_cnt = cnt; v.exp_act = act; v.exp_p1 = p1; v.exp_p2 = p2; v.push = push;
    return v;
  endfunction

  task automatic press(input logic [3:0] d, input logic c, input logic e, input int unsigned hold);
    kp_if.btn_digit = d;
    kp_if.btn_clear = c;
    kp_if.btn_enter = e;
    repeat (hold) @(negedge clk);
    kp_if.btn_digit = '0;
    kp_if.btn_clear = 1'b0;
    kp_if.btn_enter = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic expect_submit(input logic [1:0] p1, input logic [1:0] p2);
    sb_q.push_back({p1, p2});
    npushed++;
  endtask

  // Scoreboard side: every pwd_valid must match the oldest expected submission.
  always @(negedge clk) begin
    if (kp_if.pwd_valid) begin
      nvalid++;
      if (sb_q.size() == 0) begin
        chk("unexpected_pwd_valid", 32'(kp_if.pwd_valid), 0);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("submit_pw", 32'({kp_if.password_1, kp_if.password_2}), 32'(sb_exp));
      end
      if (kp_if.timeout_err) chk("valid_tmo_overlap", 32'(kp_if.timeout_err), 0);
    end
    if (kp_if.timeout_err && !tmo_allow)
      chk("unexpected_timeout", 32'(kp_if.timeout_err), 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    bit          seen;

    checks = 0; errors = 0; nvalid = 0; npushed = 0; tmo_allow = 1'b0;
    reset_n = 1'b0;
    kp_if.arm = 1'b0; kp_if.btn_digit = '0; kp_if.btn_clear = 1'b0; kp_if.btn_enter = 1'b0;

    //           arm dig     clr   ent  hold cnt act p1 p2 push
    tbl[0]  = mk(1, 4'b0000, 0, 0,  2, 0, 1, 0, 0, 0);  // arm -> WAIT_D1
    tbl[1]  = mk(1, 4'b0010, 0, 0, 10, 1, 1, 0, 0, 0);  // digit 1
    tbl[2]  = mk(1, 4'b0100, 0, 0, 10, 2, 1, 0, 0, 0);  // digit 2
    tbl[3]  = mk(1, 4'b0000, 0, 1, 10, 2, 1, 1, 2, 1);  // enter -> submit 1,2
    tbl[4]  = mk(1, 4'b0000, 0, 0,  5, 2, 1, 1, 2, 0);  // held in HOLD
    tbl[5]  = mk(1, 4'b1000, 0, 0, 10, 2, 1, 1, 2, 0);  // digit ignored in HOLD
    tbl[6]  = mk(1, 4'b0000, 1, 0, 10, 0, 1, 0, 0, 0);  // clear -> WAIT_D1, pw zeroed
    tbl[7]  = mk(1, 4'b1000, 0, 0,  2, 0, 1, 0, 0, 0);  // 2-cycle glitch
    tbl[8]  = mk(1, 4'b0001, 0, 0, 10, 1, 1, 0, 0, 0);  // digit 0
    tbl[9]  = mk(1, 4'b0000, 1, 0, 10, 0, 1, 0, 0, 0);  // clear
    tbl[10] = mk(1, 4'b1000, 0, 0, 10, 1, 1, 0, 0, 0);  // digit 3
    tbl[11] = mk(1, 4'b1000, 0, 0, 10, 2, 1, 0, 0, 0);  // digit 3
    tbl[12] = mk(1, 4'b0001, 0, 0, 10, 2, 1, 0, 0, 0);  // digit ignored in WAIT_ENTER
    tbl[13] = mk(1, 4'b0000, 0, 1, 10, 2, 1, 3, 3, 1);  // enter -> submit 3,3
    tbl[14] = mk(1, 4'b0000, 1, 0, 10, 0, 1, 0, 0, 0);  // clear from HOLD
    tbl[15] = mk(1, 4'b0101, 0, 0, 10, 0, 1, 0, 0, 0);  // simultaneous 0+2 ignored
    tbl[16] = mk(1, 4'b0100, 0, 0, 10, 1, 1, 0, 0, 0);  // single 2 accepted
    tbl[17] = mk(1, 4'b0010, 0, 0, 10, 2, 1, 0, 0, 0);  // digit 1
    tbl[18] = mk(0, 4'b0000, 0, 0,  1, 0, 0, 0, 0, 0);  // arm drop -> IDLE

    repeat (3) @(negedge clk);
    chk("rst_pw1",    32'(kp_if.password_1),   0);
    chk("rst_pw2",    32'(kp_if.password_2),   0);
    chk("rst_valid",  32'(kp_if.pwd_valid),    0);
    chk("rst_active", 32'(kp_if.entry_active), 0);
    chk("rst_cnt",    32'(kp_if.digit_count),  0);
    chk("rst_tmo",    32'(kp_if.timeout_err),  0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      kp_if.arm = tbl[i].arm;
      if (tbl[i].push) expect_submit(tbl[i].exp_p1, tbl[i].exp_p2);
      press(tbl[i].dig, tbl[i].clr, tbl[i].ent, tbl[i].hold);
      chk($sformatf("step%0d_cnt", i),    32'(kp_if.digit_count),  32'(tbl[i].exp_cnt));
      chk($sformatf("step%0d_active", i), 32'(kp_if.entry_active), 32'(tbl[i].exp_act));
      chk($sformatf("step%0d_pw1", i),    32'(kp_if.password_1),   32'(tbl[i].exp_p1));
      chk($sformatf("step%0d_pw2", i),    32'(kp_if.password_2),   32'(tbl[i].exp_p2));
    end

    // Inactivity timeout: measured from the cycle digit_count shows the accepted digit.
    tmo_allow = 1'b1;
    kp_if.arm = 1'b1;
    repeat (2) @(negedge clk);
    kp_if.btn_digit = 4'b0010;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (kp_if.digit_count == 2'd1) seen = 1'b1;
    end
    kp_if.btn_digit = '0;
    chk("tmo_digit_accepted", 32'(seen), 1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (kp_if.timeout_err) seen = 1'b1;
    end
    chk("tmo_fired",   32'(seen), 1);
    chk("tmo_latency", n, 50);
    chk("tmo_cnt",     32'(kp_if.digit_count),  0);
    chk("tmo_active",  32'(kp_if.entry_active), 1);
    @(negedge clk);
    chk("tmo_pulse_width", 32'(kp_if.timeout_err), 0);
    tmo_allow = 1'b0;
    kp_if.arm = 1'b0;
    repeat (3) @(negedge clk);

    // Arm drop in WAIT_ENTER with enter held: IDLE next cycle, no submission.
    kp_if.arm = 1'b1;
    repeat (2) @(negedge clk);
    press(4'b1000, 1'b0, 1'b0, 10);
    press(4'b0001, 1'b0, 1'b0, 10);
    chk("drop_pre_cnt", 32'(kp_if.digit_count), 2);
    kp_if.arm = 1'b0;
    kp_if.btn_enter = 1'b1;
    @(negedge clk);
    chk("drop_active", 32'(kp_if.entry_active), 0);
    chk("drop_cnt",    32'(kp_if.digit_count),  0);
    chk("drop_pw1",    32'(kp_if.password_1),   0);
    chk("drop_pw2",    32'(kp_if.password_2),   0);
    repeat (12) @(negedge clk);
    kp_if.btn_enter = 1'b0;
    repeat (10) @(negedge clk);
    chk("drop_still_idle", 32'(kp_if.entry_active), 0);

    // Submit 2,1 then assert reset mid-debounce of another button.
    kp_if.arm = 1'b1;
    repeat (2) @(negedge clk);
    expect_submit(2'd2, 2'd1);
    press(4'b0100, 1'b0, 1'b0, 10);
    press(4'b0010, 1'b0, 1'b0, 10);
    press(4'b0000, 1'b0, 1'b1, 10);
    chk("pre_rst_pw1", 32'(kp_if.password_1),   2);
    chk("pre_rst_pw2", 32'(kp_if.password_2),   1);
    chk("pre_rst_act", 32'(kp_if.entry_active), 1);
    kp_if.btn_digit = 4'b1000;
    repeat (2) @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_pw1",    32'(kp_if.password_1),   0);
    chk("async_rst_pw2",    32'(kp_if.password_2),   0);
    chk("async_rst_valid",  32'(kp_if.pwd_valid),    0);
    chk("async_rst_active", 32'(kp_if.entry_active), 0);
    chk("async_rst_cnt",    32'(kp_if.digit_count),  0);
    chk("async_rst_tmo",    32'(kp_if.timeout_err),  0);
    kp_if.arm = 1'b0;
    kp_if.btn_digit = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_active", 32'(kp_if.entry_active), 0);

    chk("sb_drained",  32'(sb_q.size()), 0);
    chk("valid_count", 32'(nvalid), 32'(npushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
